// File: rtl/test_result_monitor.sv
// riscv-tests completion checker: snoops register-file write-back, watches x3/x26/x27,
// and latches PASS/FAIL after a drain window, or TIMEOUT from a cycle watchdog.
module test_result_monitor #(
    parameter int unsigned DRAIN_CYCLES = 10,
    parameter logic [31:0] MAX_CYCLES   = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        halt_req,
    output logic [31:0] fail_testnum,
    output logic [31:0] cycle_count,
    output logic [2:0]  dbg_state,
    output logic [31:0] dbg_x26
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_DRAIN   = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] MAX_LAST   = MAX_CYCLES - 32'd1;

    state_t      state, state_nx;
    logic [31:0] x3_s, x26_s, x27_s;
    logic [31:0] drain_cnt;
    logic        trigger;

    assign trigger = wb_we && (wb_rd == 5'd26) && (wb_data == 32'd1);

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN: begin
                // A trigger on the final watchdog edge still wins.
                if (trigger)
                    state_nx = S_DRAIN;
                else if (cycle_count == MAX_LAST)
                    state_nx = S_TIMEOUT;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST)
                    state_nx = (x27_s == 32'd1) ? S_PASS : S_FAIL;
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            x3_s         <= 32'd0;
            x26_s        <= 32'd0;
            x27_s        <= 32'd0;
            drain_cnt    <= 32'd0;
            cycle_count  <= 32'd0;
            fail_testnum <= 32'd0;
        end else begin
            state <= state_nx;
            // Shadows keep tracking even after a terminal state is reached.
            if (wb_we) begin
                case (wb_rd)
                    5'd3:    x3_s  <= wb_data;
                    5'd26:   x26_s <= wb_data;
                    5'd27:   x27_s <= wb_data;
                    default: ;
                endcase
            end
            if ((state == S_RUN || state == S_DRAIN) && cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;
            if (state == S_RUN && trigger)
                drain_cnt <= 32'd0;
            else if (state == S_DRAIN)
                drain_cnt <= drain_cnt + 32'd1;
            if (state == S_DRAIN && state_nx == S_FAIL)
                fail_testnum <= x3_s;
        end
    end

    // Flags decode straight from the state register, so they are glitch-free and registered.
    assign pass      = (state == S_PASS);
    assign fail      = (state == S_FAIL);
    assign timeout   = (state == S_TIMEOUT);
    assign done      = pass | fail | timeout;
    assign halt_req  = done;
    assign dbg_state = state;
    assign dbg_x26   = x26_s;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor: table of write-back vectors with expected
// status after each group of edges, plus hand sequences for async reset corners.
module tb_test_result_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        done, pass, fail, timeout, halt_req;
    logic [31:0] fail_testnum, cycle_count, dbg_x26;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    test_result_monitor #(.DRAIN_CYCLES(10), .MAX_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .halt_req(halt_req),
        .fail_testnum(fail_testnum), .cycle_count(cycle_count),
        .dbg_state(dbg_state), .dbg_x26(dbg_x26)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          do_rst;
        int          n;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ep, ef, et;
        logic [31:0] eftn, ecc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit do_rst, input int n, input logic we, input logic [4:0] rd,
                       input logic [31:0] data, input logic ep, input logic ef, input logic et,
                       input logic [31:0] eftn, input logic [31:0] ecc);
        vec_t v;
        v.do_rst = do_rst; v.n = n; v.we = we; v.rd = rd; v.data = data;
        v.ep = ep; v.ef = ef; v.et = et; v.eftn = eftn; v.ecc = ecc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    // Called at posedge+1; leaves time at posedge+1 after release.
    task automatic do_reset();
        rst = 1'b1;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic apply(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_we = we; wb_rd = rd; wb_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input int idx, input logic ep, input logic ef, input logic et,
                              input logic [31:0] eftn, input logic [31:0] ecc);
        chk("pass", idx, 32'(pass), 32'(ep));
        chk("fail", idx, 32'(fail), 32'(ef));
        chk("timeout", idx, 32'(timeout), 32'(et));
        chk("done", idx, 32'(done), 32'(ep | ef | et));
        chk("halt_req", idx, 32'(halt_req), 32'(ep | ef | et));
        chk("fail_testnum", idx, fail_testnum, eftn);
        chk("cycle_count", idx, cycle_count, ecc);
    endtask

    initial begin
        // Pass path: x3=5, x27=1, trigger at edge 3 (t0); flags after edge 13.
        add(1, 1,  1, 5'd3,  32'd5, 0, 0, 0, 0, 1);
        add(0, 1,  1, 5'd27, 32'd1, 0, 0, 0, 0, 2);
        add(0, 1,  1, 5'd26, 32'd1, 0, 0, 0, 0, 3);
        add(0, 9,  0, 5'd0,  32'd0, 0, 0, 0, 0, 12);
        add(0, 1,  0, 5'd0,  32'd0, 1, 0, 0, 0, 13);
        add(0, 50, 0, 5'd0,  32'd0, 1, 0, 0, 0, 13);
        // Fail path with testnum 7; a later x3 write must not disturb it.
        add(1, 1,  1, 5'd3,  32'd7, 0, 0, 0, 0, 1);
        add(0, 1,  1, 5'd27, 32'd0, 0, 0, 0, 0, 2);
        add(0, 1,  1, 5'd26, 32'd1, 0, 0, 0, 0, 3);
        add(0, 9,  0, 5'd0,  32'd0, 0, 0, 0, 0, 12);
        add(0, 1,  0, 5'd0,  32'd0, 0, 1, 0, 7, 13);
        add(0, 1,  1, 5'd3,  32'd9, 0, 1, 0, 7, 13);
        add(0, 5,  0, 5'd0,  32'd0, 0, 1, 0, 7, 13);
        // x27=1 at t0+3 is seen.
        add(1, 1,  1, 5'd26, 32'd1, 0, 0, 0, 0, 1);
        add(0, 2,  0, 5'd0,  32'd0, 0, 0, 0, 0, 3);
        add(0, 1,  1, 5'd27, 32'd1, 0, 0, 0, 0, 4);
        add(0, 6,  0, 5'd0,  32'd0, 0, 0, 0, 0, 10);
        add(0, 1,  0, 5'd0,  32'd0, 1, 0, 0, 0, 11);
        // x27=1 on the evaluating edge is too late.
        add(1, 1,  1, 5'd26, 32'd1, 0, 0, 0, 0, 1);
        add(0, 9,  0, 5'd0,  32'd0, 0, 0, 0, 0, 10);
        add(0, 1,  1, 5'd27, 32'd1, 0, 1, 0, 0, 11);
        // Non-trigger x26 value and x0 writes, then a real trigger.
        add(1, 1,  1, 5'd26, 32'd2, 0, 0, 0, 0, 1);
        add(0, 15, 0, 5'd0,  32'd0, 0, 0, 0, 0, 16);
        add(0, 1,  1, 5'd3,  32'd4, 0, 0, 0, 0, 17);
        add(0, 3,  1, 5'd0,  32'd1, 0, 0, 0, 0, 20);
        add(0, 1,  1, 5'd26, 32'd1, 0, 0, 0, 0, 21);
        add(0, 9,  0, 5'd0,  32'd0, 0, 0, 0, 0, 30);
        add(0, 1,  0, 5'd0,  32'd0, 0, 1, 0, 4, 31);
        // Watchdog fires after edge 100 and the terminal state is sticky.
        add(1, 99, 0, 5'd0,  32'd0, 0, 0, 0, 0, 99);
        add(0, 1,  0, 5'd0,  32'd0, 0, 0, 1, 0, 100);
        add(0, 20, 0, 5'd0,  32'd0, 0, 0, 1, 0, 100);
        add(0, 1,  1, 5'd26, 32'd1, 0, 0, 1, 0, 100);
        // Trigger on the edge where cycle_count=99 beats the watchdog.
        add(1, 1,  1, 5'd27, 32'd1, 0, 0, 0, 0, 1);
        add(0, 98, 0, 5'd0,  32'd0, 0, 0, 0, 0, 99);
        add(0, 1,  1, 5'd26, 32'd1, 0, 0, 0, 0, 100);
        add(0, 9,  0, 5'd0,  32'd0, 0, 0, 0, 0, 109);
        add(0, 1,  0, 5'd0,  32'd0, 1, 0, 0, 0, 110);

        do_reset();
        chk_status(-1, 0, 0, 0, 0, 0);
        chk("reset_state", -1, 32'(dbg_state), 32'd0);

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            for (int k = 0; k < tbl[i].n; k++) apply(tbl[i].we, tbl[i].rd, tbl[i].data);
            chk_status(i, tbl[i].ep, tbl[i].ef, tbl[i].et, tbl[i].eftn, tbl[i].ecc);
        end

        // x26 shadow tracks non-trigger values; x0 writes leave it and the state alone.
        do_reset();
        apply(1, 5'd26, 32'd2);
        chk("x26_shadow", 100, dbg_x26, 32'd2);
        apply(1, 5'd0, 32'd1);
        apply(1, 5'd0, 32'd1);
        chk("x26_after_x0", 101, dbg_x26, 32'd2);
        chk("state_run", 101, 32'(dbg_state), 32'd0);

        // Async reset between edges mid-DRAIN, then a fresh trigger.
        do_reset();
        apply(1, 5'd27, 32'd1);
        apply(1, 5'd26, 32'd1);
        repeat (4) apply(0, 5'd0, 32'd0);
        chk("drain_state", 200, 32'(dbg_state), 32'd1);
        chk("drain_cc", 200, cycle_count, 32'd6);
        #4;
        rst = 1'b1;
        #1;
        chk_status(201, 0, 0, 0, 0, 0);
        chk("async_rst_state", 201, 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1, 5'd26, 32'd1);
        chk_status(202, 0, 0, 0, 0, 1);
        repeat (9) apply(0, 5'd0, 32'd0);
        chk_status(203, 0, 0, 0, 0, 10);
        apply(0, 5'd0, 32'd0);
        chk_status(204, 0, 1, 0, 0, 11);

        // Async reset clears a terminal state without waiting for an edge.
        #4;
        rst = 1'b1;
        #1;
        chk_status(205, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
